// File: rtl/ahblite_switch_ctrl_if.sv
// ahblite_switch_ctrl_if: AHB-Lite slave-side bus signals for the switch controller.
interface ahblite_switch_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_switch_ctrl.sv
// ahblite_switch_ctrl: AHB-Lite switch controller with 2-flop sync, edge flags and level irq.
// Define SWITCH_CTRL_DEBOUNCE_EN to add per-channel DEB_CYCLES debounce counters.
module ahblite_switch_ctrl #(
    parameter int NCH        = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahblite_switch_ctrl_if.slave bus,
    input  logic [NCH-1:0]       switch_in,
    output logic                 irq
);
    logic           ap_valid, ap_write, wr;
    logic [2:0]     ap_idx;
    logic [NCH-1:0] sync1, sync2, stable, stable_d, status, irq_en, edge_pol;
    logic [NCH-1:0] wdat, pol_now, edges, rd;
    logic           unused;

    assign unused = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE, bus.HPROT,
                      bus.HWDATA, DEB_CYCLES > 0};

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_idx   <= '0;
        end else if (bus.HREADY) begin
            ap_valid <= bus.HSEL & bus.HTRANS[1];
            ap_write <= bus.HWRITE;
            ap_idx   <= bus.HADDR[4:2];
        end
    end

    assign wr   = ap_valid & ap_write;
    assign wdat = bus.HWDATA[NCH-1:0];
    // a polarity write landing with an edge is judged by the new polarity
    assign pol_now = (wr && ap_idx == 3'd3) ? wdat : edge_pol;
    assign edges   = (stable ^ stable_d) & ~(stable ^ pol_now);

`ifdef SWITCH_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    logic [CW-1:0] cnt [NCH];
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            stable <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == stable[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
`else
    assign stable = sync2;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
            status   <= '0;
            irq_en   <= '0;
            edge_pol <= '0;
        end else begin
            sync1    <= switch_in;
            sync2    <= sync1;
            stable_d <= stable;
            status   <= (status & ~((wr && ap_idx == 3'd1) ? wdat : '0)) | edges;
            edge_pol <= pol_now;
            if (wr && ap_idx == 3'd2) irq_en <= wdat;
        end
    end

    always_comb begin
        rd = ap_idx == 3'd0 ? stable   :
             ap_idx == 3'd1 ? status   :
             ap_idx == 3'd2 ? irq_en   :
             ap_idx == 3'd3 ? edge_pol :
             ap_idx == 3'd4 ? sync2    : '0;
    end

    assign bus.HRDATA = (ap_valid && !ap_write) ? 32'(rd) : '0;
    assign irq        = |(status & irq_en);
endmodule

// File: tb/tb_ahblite_switch_ctrl.sv
// tb_ahblite_switch_ctrl: directed checks of the switch controller register map, debounce, edges and irq.
module tb_ahblite_switch_ctrl;
`ifdef SWITCH_CTRL_DEBOUNCE_EN
    localparam int          LAT       = 6;
    localparam logic [31:0] GL_STATUS = 32'h1;
`else
    localparam int          LAT       = 2;
    localparam logic [31:0] GL_STATUS = 32'h3;
`endif
    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [3:0] switch_in = '0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    ahblite_switch_ctrl_if bus();

    ahblite_switch_ctrl #(.NCH(4), .DEB_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus), .switch_in(switch_in), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        bus.HSEL = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = w;
        bus.HADDR = a;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        tick();
        idle();
        bus.HWDATA = d;
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr_phase(a, 1'b0);
        tick();
        idle();
        chk(tag, bus.HRDATA, exp);
    endtask

    initial begin
        bus.HREADY = 1'b1;
        bus.HSIZE = 3'd2;
        bus.HPROT = '0;
        bus.HADDR = '0;
        bus.HWDATA = '0;
        idle();
        tick();
        tick();
        chk("rst_irq", 32'(irq), 0);
        chk("rst_hrdata", bus.HRDATA, 0);
        chk("hreadyout", 32'(bus.HREADYOUT), 1);
        chk("hresp", 32'(bus.HRESP), 0);
        HRESET = 1'b0;
        rd(32'h00, 0, "rst_data");
        rd(32'h04, 0, "rst_status");
        rd(32'h08, 0, "rst_irq_en");
        rd(32'h0C, 0, "rst_edge_pol");
        rd(32'h10, 0, "rst_raw");

        // debounce latency on channel 0, rising-edge polarity
        wr(32'h0C, 32'h1);
        rd(32'h0C, 32'h1, "edge_pol_rw");
        addr_phase(32'h00, 1'b0);
        switch_in = 4'h1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk("deb_data", bus.HRDATA, (k == LAT) ? 32'h1 : 32'h0);
        end
        bus.HADDR = 32'h04;
        tick();
        idle();
        chk("deb_status", bus.HRDATA, 32'h1);
        chk("deb_irq_masked", 32'(irq), 0);

        // 3-cycle glitch on channel 1
        switch_in = 4'h3;
        tick();
        tick();
        tick();
        switch_in = 4'h1;
        repeat (12) tick();
        chk("glitch_irq", 32'(irq), 0);
        rd(32'h00, 32'h1, "glitch_data");
        rd(32'h04, GL_STATUS, "glitch_status");
        wr(32'h04, 32'hF);
        rd(32'h04, 32'h0, "w1c_all");

        // interrupt flow on channel 2, falling polarity
        wr(32'h08, 32'h4);
        wr(32'h0C, 32'h0);
        switch_in = 4'h5;
        repeat (12) tick();
        chk("irq_rise_ignored", 32'(irq), 0);
        switch_in = 4'h1;
        repeat (12) tick();
        chk("irq_fall", 32'(irq), 1);
        rd(32'h04, 32'h4, "irq_status");
        wr(32'h04, 32'h4);
        chk("irq_cleared", 32'(irq), 0);
        rd(32'h04, 32'h0, "irq_status_clr");

        // W1C on bit3 in the same cycle its edge is flagged
        wr(32'h0C, 32'h8);
        switch_in = 4'h9;
        repeat (LAT - 1) tick();
        addr_phase(32'h04, 1'b1);
        tick();
        idle();
        bus.HWDATA = 32'h8;
        tick();
        rd(32'h04, 32'h8, "set_over_clear");

        // register map corners
        rd(32'h14, 32'h0, "unmapped_read");
        wr(32'h00, 32'hF);
        rd(32'h00, 32'h9, "ro_data_write");
        rd(32'h10, 32'h9, "raw_read");
        addr_phase(32'h08, 1'b1);
        tick();
        bus.HWDATA = 32'hA;
        bus.HWRITE = 1'b0;
        tick();
        idle();
        chk("b2b_irq_en", bus.HRDATA, 32'hA);
        chk("b2b_irq", 32'(irq), 1);

        // build STATUS=0xF then reset mid-debounce
        wr(32'h0C, 32'h6);
        switch_in = 4'h6;
        repeat (12) tick();
        rd(32'h04, 32'hF, "status_all");
        chk("irq_all", 32'(irq), 1);
        switch_in = 4'h0;
        repeat (3) tick();
        HRESET = 1'b1;
        tick();
        chk("mid_rst_irq", 32'(irq), 0);
        chk("mid_rst_hrdata", bus.HRDATA, 0);
        HRESET = 1'b0;
        rd(32'h00, 0, "post_rst_data");
        rd(32'h04, 0, "post_rst_status");
        rd(32'h08, 0, "post_rst_irq_en");
        rd(32'h0C, 0, "post_rst_edge_pol");
        rd(32'h10, 0, "post_rst_raw");

        // reset during a write data phase drops the write
        addr_phase(32'h0C, 1'b1);
        tick();
        idle();
        bus.HWDATA = 32'hF;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        rd(32'h0C, 0, "rst_drop_write");

        repeat (10) tick();
        chk("quiet_irq", 32'(irq), 0);
        rd(32'h04, 0, "quiet_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahblite_switch_ctrl.md
AHBLITE_SWITCH_CTRL -- requirements
Module: ahblite_switch_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of switch channels, 1..32.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: debounce hold count, 2..65535.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port list:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  address; bits [4:2] decoded
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size; ignored, word access only
- HPROT  in  4  ignored
- HWRITE  in  1  write strobe
- HWDATA  in  32  write data
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  read data
- HRESP  out  1  response
- switch_in  in  NCH  raw asynchronous switch inputs
- irq  out  1  level interrupt to core IRQ line

Function
REQ-005 SHALL tie HREADYOUT=1 and HRESP=0: zero-wait-state, never errors.
REQ-006 SHALL capture an address phase only when HSEL & HREADY & HTRANS[1]; SHALL register word index HADDR[4:2] and HWRITE.
REQ-007 SHALL apply a write in the data phase that follows, using HWDATA[NCH-1:0].
REQ-008 SHALL drive HRDATA combinationally from the registered index during the data phase; upper bits above NCH read 0.
REQ-009 SHALL implement this register map:
- 0x00 DATA: debounced levels, RO
- 0x04 STATUS: sticky edge flags, write-1-to-clear
- 0x08 IRQ_EN: RW
- 0x0C EDGE_POL: RW, 1=rising, 0=falling
- 0x10 RAW: synchroniser output, RO
REQ-010 SHALL return 0 on reads of unmapped offsets and SHALL ignore writes to unmapped offsets and to RO registers.
REQ-011 SHALL synchronise each switch_in bit through 2 flops.
REQ-012 SHALL keep one debounce counter per channel:
- counter increments each cycle that the sync output differs from stable;
- counter clears to 0 on any cycle of agreement;
- on the DEB_CYCLES-th consecutive mismatch edge, stable <= sync output and counter <= 0.
REQ-013 SHALL therefore update DATA DEB_CYCLES+2 clock edges after a pin change that is held constant; glitches shorter than DEB_CYCLES cycles SHALL produce no change.
REQ-014 SHALL detect an edge when stable differs from its 1-cycle-delayed copy and the direction matches EDGE_POL; the STATUS bit SHALL set one edge after DATA changes.
REQ-015 SHALL drive irq = |(STATUS & IRQ_EN), combinationally from registers.
REQ-016 SHALL give set priority over clear when a W1C and a new edge hit the same STATUS bit in the same cycle.
REQ-017 SHALL not clear STATUS when IRQ_EN is written; clearing IRQ_EN masks irq only.
REQ-018 SHALL record an edge in STATUS when its EDGE_POL bit changes in the same cycle as the stable edge, using the new polarity.

Reset
REQ-019 SHALL, when HRESET is sampled high, clear all state to 0: sync flops, stable, delayed copy, counters, STATUS, IRQ_EN, EDGE_POL and the registered address phase.
REQ-020 SHALL, on reset, hold irq=0 and HRDATA=0.
REQ-021 SHALL cause no spurious edge flags after reset when switch_in=0.
REQ-022 SHALL, if reset is asserted mid-debounce, discard the partial count.
REQ-023 SHALL, if reset is asserted mid-transfer, drop the pending write.

Configuration
REQ-024 SHALL, with SWITCH_CTRL_DEBOUNCE_EN defined, implement REQ-012/REQ-013 as written.
REQ-025 SHALL, without SWITCH_CTRL_DEBOUNCE_EN, omit the counters and set stable = sync output directly, giving DATA latency 2 edges; DEB_CYCLES is ignored and the register map is unchanged.

Verification (NCH=4, DEB_CYCLES=4, macro defined)
REQ-026 SHALL cover debounce: switch_in[0] 0->1 held -> DATA=0x1 exactly 6 edges later; STATUS bit0=1 at 7 edges with EDGE_POL[0]=1.
REQ-027 SHALL cover glitch rejection: switch_in[1] high for 3 cycles then low -> DATA and STATUS stay 0, irq stays 0.
REQ-028 SHALL cover interrupt flow: write IRQ_EN=0x4, EDGE_POL=0x0, switch_in[2] 1->0 after a stable 1 -> irq=1; write STATUS=0x4 -> irq=0 the following cycle.
REQ-029 SHALL cover set-over-clear: W1C of STATUS bit3 in the same cycle as a new bit3 edge -> bit3 reads 1 afterwards.
REQ-030 SHALL cover the map: read 0x14 -> 0; write 0x00 with 0xF -> DATA unchanged; back-to-back write IRQ_EN then read IRQ_EN -> new value returned.
REQ-031 SHALL cover reset: HRESET=1 for one cycle mid-debounce with STATUS=0xF -> all registers 0, irq=0, no edge flagged for 10 cycles with switch_in=0.
